// File: rtl/cep_define.sv
// Shared PMP types: cfg byte layout, address-match modes, access kinds, CSR numbers
// and the sequential checker's FSM states.
package cep_define;

    localparam int PMP_MAX_ENTRIES = 16;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } mode;

    typedef enum logic [1:0] {
        READ    = 2'd0,
        WRITE   = 2'd1,
        EXECUTE = 2'd2,
        NOTHING = 2'd3
    } operations;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        mode        a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg;

    typedef enum logic [11:0] {
        CSR_PMPCFG0   = 12'h3A0,
        CSR_PMPCFG3   = 12'h3A3,
        CSR_PMPADDR0  = 12'h3B0,
        CSR_PMPADDR15 = 12'h3BF
    } pmp_csr_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } pmp_chk_state_e;

    // Reserved bits read as zero and the W=1/R=0 combination is not storable.
    function automatic pmpcfg sanitize_cfg(input logic [7:0] raw);
        pmpcfg c;
        c = pmpcfg'(raw);
        c.rsvd = 2'b00;
        if (c.w && !c.r) begin
            c.w = 1'b0;
        end
        return c;
    endfunction

    function automatic logic pmp_allow(input pmpcfg c, input operations op, input logic priv_m);
        logic ok;
        ok = 1'b1;
        if (op != NOTHING && !(priv_m && !c.l)) begin
            case (op)
                READ:    ok = c.r;
                WRITE:   ok = c.w;
                EXECUTE: ok = c.x;
                default: ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/pmp_seq_checker_entry_match.sv
// Combinational address match of one PMP entry against a 32-bit word address.
module pmp_entry_match
    import cep_define::*;
(
    input  logic [31:0] word_addr,
    input  pmpcfg       cfg,
    input  logic [31:0] addr_hi,
    input  logic [31:0] addr_lo,
    output logic        match
);

    logic [31:0] napot_mask;
    logic        cfg_unused;

    assign cfg_unused = ^{cfg.l, cfg.rsvd, cfg.x, cfg.w, cfg.r};

    always_comb begin
        // Trailing ones plus the following zero are don't-care bits of the region.
        napot_mask = ~(addr_hi ^ (addr_hi + 32'd1));
        match      = 1'b0;
        case (cfg.a)
            OFF:     match = 1'b0;
            NA4:     match = (word_addr == addr_hi);
            NAPOT:   match = ((word_addr & napot_mask) == (addr_hi & napot_mask));
            TOR:     match = (word_addr >= addr_lo) && (word_addr < addr_hi);
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: CSR-programmed entries, scanned LANES at a time per cycle,
// one request in flight with a held response.
module pmp_seq_checker
    import cep_define::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int LANES       = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           csr_we,
    input  logic [11:0]                    csr_addr,
    input  logic [31:0]                    csr_wdata,
    output logic [31:0]                    csr_rdata,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [33:0]                    req_addr,
    input  operations                      req_op,
    input  logic                           req_priv_m,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_allow,
    output logic                           rsp_matched,
    output logic [$clog2(NUM_ENTRIES)-1:0] rsp_idx
);

    localparam int IDX_W      = $clog2(NUM_ENTRIES);
    localparam int NUM_GROUPS = NUM_ENTRIES / LANES;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;

    pmpcfg            cfg_reg  [NUM_ENTRIES];
    logic [31:0]      addr_reg [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] addr_locked;

    pmp_chk_state_e   state_reg;
    logic [GRP_W-1:0] group_reg;
    logic [31:0]      word_reg;
    operations        op_reg;
    logic             priv_reg;

    logic [LANES-1:0]  lane_match;
    logic              hit;
    logic [LANE_W-1:0] hit_lane;
    logic [IDX_W-1:0]  hit_idx;
    pmpcfg             hit_cfg;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^req_addr[1:0];
    assign req_ready       = (state_reg == IDLE);

    genvar gi;
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_lock
        if (gi == NUM_ENTRIES - 1) begin : g_last
            assign addr_locked[gi] = cfg_reg[gi].l;
        end else begin : g_mid
            // A locked TOR entry above also freezes this entry's address (its lower bound).
            assign addr_locked[gi] = cfg_reg[gi].l | (cfg_reg[gi+1].l & (cfg_reg[gi+1].a == TOR));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cfg_reg[i]  <= '0;
                addr_reg[i] <= '0;
            end
        end else if (csr_we) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (int'(csr_addr) == int'(CSR_PMPCFG0) + i / 4 && !cfg_reg[i].l) begin
                    cfg_reg[i] <= sanitize_cfg(csr_wdata[(i % 4) * 8 +: 8]);
                end
                if (int'(csr_addr) == int'(CSR_PMPADDR0) + i && !addr_locked[i]) begin
                    addr_reg[i] <= csr_wdata;
                end
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (int'(csr_addr) == int'(CSR_PMPCFG0) + i / 4) begin
                csr_rdata[(i % 4) * 8 +: 8] = cfg_reg[i];
            end
            if (int'(csr_addr) == int'(CSR_PMPADDR0) + i) begin
                csr_rdata = addr_reg[i];
            end
        end
    end

    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [IDX_W-1:0] ent;
        logic [IDX_W-1:0] prev;
        logic [31:0]      lo;

        assign ent  = IDX_W'(int'(group_reg) * LANES + gi);
        assign prev = (ent == '0) ? '0 : ent - 1'b1;
        assign lo   = (ent == '0) ? 32'd0 : addr_reg[prev];

        pmp_entry_match u_match (
            .word_addr (word_reg),
            .cfg       (cfg_reg[ent]),
            .addr_hi   (addr_reg[ent]),
            .addr_lo   (lo),
            .match     (lane_match[gi])
        );
    end

    always_comb begin
        hit      = 1'b0;
        hit_lane = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_match[l]) begin
                hit      = 1'b1;
                hit_lane = LANE_W'(l);
            end
        end
        hit_idx = IDX_W'(int'(group_reg) * LANES + int'(hit_lane));
        hit_cfg = cfg_reg[hit_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            group_reg   <= '0;
            word_reg    <= '0;
            op_reg      <= READ;
            priv_reg    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_allow   <= 1'b0;
            rsp_matched <= 1'b0;
            rsp_idx     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        word_reg  <= req_addr[33:2];
                        op_reg    <= req_op;
                        priv_reg  <= req_priv_m;
                        group_reg <= '0;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        state_reg   <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_matched <= 1'b1;
                        rsp_idx     <= hit_idx;
                        rsp_allow   <= pmp_allow(hit_cfg, op_reg, priv_reg);
                    end else if (group_reg == GRP_W'(NUM_GROUPS - 1)) begin
                        state_reg   <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_matched <= 1'b0;
                        rsp_idx     <= '0;
                        rsp_allow   <= priv_reg | (op_reg == NOTHING);
                    end else begin
                        group_reg <= group_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Directed bench for pmp_seq_checker with a rule-level PMP model and a per-cycle response monitor.
module tb_pmp_seq_checker;
    import cep_define::*;

    localparam int N = 16;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [33:0] req_addr = '0;
    operations   req_op = READ;
    logic        req_priv_m = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_allow;
    logic        rsp_matched;
    logic [3:0]  rsp_idx;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_cfg  [N];
    logic [31:0] m_addr [N];

    logic resp_expected = 1'b0;
    logic exp_allow = 1'b0;
    logic exp_matched = 1'b0;
    int   exp_idx = 0;

    pmp_seq_checker #(.NUM_ENTRIES(N), .LANES(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_op      (req_op),
        .req_priv_m  (req_priv_m),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_allow   (rsp_allow),
        .rsp_matched (rsp_matched),
        .rsp_idx     (rsp_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_cfg[i]  = 8'h00;
            m_addr[i] = 32'h0;
        end
    endfunction

    function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
        int i;
        logic [7:0] v;
        logic locked;
        if (a >= 12'h3A0 && a <= 12'h3A3) begin
            for (int b = 0; b < 4; b++) begin
                i = (int'(a) - 'h3A0) * 4 + b;
                if (i < N && !m_cfg[i][7]) begin
                    v = d[b*8 +: 8] & 8'h9F;
                    if (v[1] && !v[0]) v[1] = 1'b0;
                    m_cfg[i] = v;
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            i = int'(a) - 'h3B0;
            if (i < N) begin
                locked = m_cfg[i][7];
                if (i + 1 < N && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'd1) locked = 1'b1;
                if (!locked) m_addr[i] = d;
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [31:0] v;
        int i;
        v = '0;
        if (a >= 12'h3A0 && a <= 12'h3A3) begin
            for (int b = 0; b < 4; b++) begin
                i = (int'(a) - 'h3A0) * 4 + b;
                if (i < N) v[b*8 +: 8] = m_cfg[i];
            end
        end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            i = int'(a) - 'h3B0;
            if (i < N) v = m_addr[i];
        end
        return v;
    endfunction

    function automatic bit entry_hit(input int i, input logic [31:0] a);
        logic [63:0] lo, hi, base, size, wa;
        int k;
        wa = {32'd0, a};
        hi = {32'd0, m_addr[i]};
        case (m_cfg[i][4:3])
            2'd0: return 1'b0;
            2'd2: return a == m_addr[i];
            2'd3: begin
                k = 0;
                while (k < 32 && m_addr[i][k]) k++;
                size = 64'd1 << (k + 1);
                base = hi & ~(size - 64'd1);
                return (wa >= base) && (wa < base + size);
            end
            default: begin
                lo = 64'd0;
                if (i > 0) lo = {32'd0, m_addr[i-1]};
                return (wa >= lo) && (wa < hi);
            end
        endcase
    endfunction

    function automatic void model_eval(input logic [33:0] ba, input operations op, input logic pm,
                                       output logic m, output int idx, output logic al, output int lat);
        logic [7:0] c;
        m = 1'b0;
        idx = 0;
        for (int i = 0; i < N; i++) begin
            if (!m && entry_hit(i, ba[33:2])) begin
                m = 1'b1;
                idx = i;
            end
        end
        if (m) begin
            c = m_cfg[idx];
            if (op == NOTHING || (pm && !c[7])) al = 1'b1;
            else if (op == READ) al = c[0];
            else if (op == WRITE) al = c[1];
            else al = c[2];
            lat = idx / L + 2;
        end else begin
            al = pm || (op == NOTHING);
            lat = N / L + 1;
        end
    endfunction

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1;
        csr_addr = a;
        csr_wdata = d;
        @(posedge clk); #1;
        csr_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic csr_check(input string nm, input logic [11:0] a);
        csr_addr = a;
        #1;
        check(nm, csr_rdata, model_read(a));
    endtask

    // Per-cycle response monitor: every rsp_valid cycle must be expected and carry the model's fields.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            check("rsp_valid expected", resp_expected, 1'b1);
            if (resp_expected) begin
                check("rsp_allow", rsp_allow, exp_allow);
                check("rsp_matched", rsp_matched, exp_matched);
                check("rsp_idx", rsp_idx, exp_idx);
            end
        end
    end

    task automatic do_req(input string nm, input logic [33:0] ba, input operations op, input logic pm,
                          input int stall, input int ex_allow, input int ex_matched,
                          input int ex_idx, input int ex_lat);
        logic m, al;
        int idx, lat, seen;
        model_eval(ba, op, pm, m, idx, al, lat);
        if (ex_allow >= 0)   check({nm, " model allow"}, al, ex_allow);
        if (ex_matched >= 0) check({nm, " model matched"}, m, ex_matched);
        if (ex_idx >= 0)     check({nm, " model idx"}, idx, ex_idx);
        if (ex_lat >= 0)     check({nm, " model latency"}, lat, ex_lat);
        exp_allow = al;
        exp_matched = m;
        exp_idx = idx;
        resp_expected = 1'b1;
        check({nm, " req_ready idle"}, req_ready, 1'b1);
        rsp_ready = (stall == 0);
        req_valid = 1'b1;
        req_addr = ba;
        req_op = op;
        req_priv_m = pm;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = 34'h3_FFFF_FFFF;
        req_op = NOTHING;
        req_priv_m = ~pm;
        seen = 1;
        while (!rsp_valid && seen < 40) begin
            @(posedge clk); #1;
            seen++;
        end
        check({nm, " latency"}, seen, lat);
        for (int k = 0; k < stall; k++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            check({nm, " stall rsp_valid"}, rsp_valid, 1'b1);
            check({nm, " stall req_ready"}, req_ready, 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({nm, " rsp_valid drop"}, rsp_valid, 1'b0);
        resp_expected = 1'b0;
        $display("txn %s addr=0x%0h op=%0d m=%0b -> allow=%0b matched=%0b idx=%0d lat=%0d",
                 nm, ba, op, pm, al, m, idx, seen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", req_ready, 1'b1);
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset rsp_allow", rsp_allow, 1'b0);
        check("reset rsp_matched", rsp_matched, 1'b0);
        check("reset rsp_idx", rsp_idx, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        csr_check("reset pmpcfg0", 12'h3A0);
        csr_check("reset pmpaddr7", 12'h3B7);

        // W=1/R=0 is not storable; reserved bits are dropped.
        csr_write(12'h3A0, 32'h0000_0002);
        check("model cfg0 W-without-R", model_read(12'h3A0), 32'h0);
        csr_check("pmpcfg0 W-without-R", 12'h3A0);
        csr_write(12'h3A1, 32'h0000_0060);
        csr_check("pmpcfg1 reserved", 12'h3A1);
        csr_check("non-PMP csr", 12'h300);

        // TOR entry 0 over [0, 0x100) words.
        csr_write(12'h3B0, 32'h0000_0100);
        csr_write(12'h3A0, 32'h0000_000B);
        csr_check("pmpaddr0", 12'h3B0);
        csr_check("pmpcfg0 tor", 12'h3A0);
        do_req("tor_read_u", 34'h3FC, READ, 1'b0, 0, 1, 1, 0, 2);
        do_req("tor_exec_u", 34'h10, EXECUTE, 1'b0, 0, 0, 1, 0, 2);

        // NAPOT entry 5: 4 KiB at 0, read-only.
        csr_write(12'h3B5, 32'h0000_01FF);
        csr_write(12'h3A1, 32'h0000_1900);
        csr_check("pmpcfg1 napot", 12'h3A1);
        do_req("napot_write_u", 34'h800, WRITE, 1'b0, 0, 0, 1, 5, 4);
        do_req("napot_read_u", 34'h800, READ, 1'b0, 0, 1, 1, 5, 4);

        // Locked TOR entry 3 over [0x300, 0x400) freezes cfg3, pmpaddr3 and pmpaddr2.
        csr_write(12'h3B2, 32'h0000_0300);
        csr_write(12'h3B3, 32'h0000_0400);
        csr_write(12'h3A0, 32'h8800_000B);
        csr_write(12'h3B2, 32'h0000_0055);
        csr_write(12'h3A0, 32'h0000_000B);
        csr_write(12'h3B3, 32'h0000_0999);
        check("model pmpaddr2 locked", model_read(12'h3B2), 32'h300);
        csr_check("pmpaddr2 locked", 12'h3B2);
        csr_check("pmpcfg0 locked", 12'h3A0);
        csr_check("pmpaddr3 locked", 12'h3B3);
        do_req("locked_read_m", 34'hD40, READ, 1'b1, 0, 0, 1, 3, 3);

        // Unmapped address: full scan.
        do_req("unmapped_read_u", 34'h2_0000_0000, READ, 1'b0, 0, 0, 0, 0, 9);
        do_req("unmapped_read_m", 34'h2_0000_0000, READ, 1'b1, 0, 1, 0, 0, 9);
        do_req("unmapped_nothing_u", 34'h2_0000_0000, NOTHING, 1'b0, 0, 1, 0, 0, 9);

        // NA4 entry 8, RWX.
        csr_write(12'h3B8, 32'h0000_1234);
        csr_write(12'h3A2, 32'h0000_0017);
        do_req("na4_write_u", 34'h48D0, WRITE, 1'b0, 0, 1, 1, 8, 6);
        do_req("na4_miss_u", 34'h48D4, WRITE, 1'b0, 0, 0, 0, 0, 9);

        // Backpressure with a competing request.
        do_req("stall_read_u", 34'h3FC, READ, 1'b0, 5, 1, 1, 0, 2);

        // Reset mid-scan, together with a CSR write that must lose.
        resp_expected = 1'b0;
        req_valid = 1'b1;
        req_addr = 34'h2_0000_0000;
        req_op = READ;
        req_priv_m = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        csr_we = 1'b1;
        csr_addr = 12'h3B1;
        csr_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0;
        csr_we = 1'b0;
        model_clear();
        check("post-reset req_ready", req_ready, 1'b1);
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("post-reset rsp_valid", rsp_valid, 1'b0);
        check("post-reset rsp_matched", rsp_matched, 1'b0);
        for (int c = 0; c < 4; c++) csr_check("post-reset pmpcfg", 12'(12'h3A0 + c));
        for (int c = 0; c < 16; c++) csr_check("post-reset pmpaddr", 12'(12'h3B0 + c));
        do_req("post_reset_read_u", 34'h0, READ, 1'b0, 0, 0, 0, 0, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
